// File: rtl/usb_cmd_engine_if.sv
// mux_usb_interface: word-access port between the USB command engine (usb) and the memory mux (mux).
interface mux_usb_interface;
  logic [25:0] usb_addr;
  logic        usb_rd;
  logic        usb_wr;
  logic [31:0] usb_wr_data;
  logic        usb_wr_ready;
  logic [31:0] usb_rd_data;
  logic        usb_rd_valid;
  modport usb (output usb_addr, usb_rd, usb_wr, usb_wr_data, input usb_wr_ready, usb_rd_data, usb_rd_valid);
  modport mux (input usb_addr, usb_rd, usb_wr, usb_wr_data, output usb_wr_ready, usb_rd_data, usb_rd_valid);
endinterface

// File: rtl/usb_cmd_engine.sv
// usb_cmd_engine: byte command stream to 32-bit mux reads/writes; status bytes only with USB_CMD_STATUS_EN.
module usb_cmd_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  mux_usb_interface.usb usb
);
  typedef enum logic [2:0] {IDLE, HDR, WR_COLLECT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_SEND, STATUS} state_t;
`ifdef USB_CMD_STATUS_EN
  localparam state_t DONE = STATUS;
`else
  localparam state_t DONE = IDLE;
`endif
  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [25:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  status_q, status_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        usb_rd_q, usb_rd_d;
  logic        usb_wr_q, usb_wr_d;
  logic        rx_fire, tx_fire;
  assign rx_fire = rx_valid && rx_ready_q;
  assign tx_fire = tx_valid_q && tx_ready;
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    len_d    = len_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (rx_fire) begin
        cnt_d    = '0;
        is_wr_d  = rx_data == 8'h02;
        status_d = 8'hEE;
        state_d  = (rx_data == 8'h01 || rx_data == 8'h02) ? HDR : DONE;
      end
      HDR: if (rx_fire) begin
        cnt_d = cnt_q + 3'd1;
        case (cnt_q)
          3'd0:    addr_d[7:0]   = rx_data;
          3'd1:    addr_d[15:8]  = rx_data;
          3'd2:    addr_d[23:16] = rx_data;
          3'd3:    addr_d[25:24] = rx_data[1:0];
          3'd4:    len_d[7:0]    = rx_data;
          default: len_d[15:8]   = rx_data;
        endcase
        if (cnt_q == 3'd5) begin
          cnt_d    = '0;
          status_d = 8'hA5;
          state_d  = len_d == 16'd0 ? DONE : is_wr_q ? WR_COLLECT : RD_ISSUE;
        end
      end
      WR_COLLECT: if (rx_fire) begin
        data_d = {rx_data, data_q[31:8]};
        cnt_d  = cnt_q == 3'd3 ? 3'd0 : cnt_q + 3'd1;
        state_d = cnt_q == 3'd3 ? WR_ISSUE : WR_COLLECT;
      end
      WR_ISSUE: if (usb.usb_wr_ready) begin
        addr_d  = addr_q + 26'd4;
        len_d   = len_q - 16'd1;
        state_d = len_q == 16'd1 ? DONE : WR_COLLECT;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: if (usb.usb_rd_valid) begin
        data_d  = usb.usb_rd_data;
        state_d = RD_SEND;
      end
      RD_SEND: if (tx_fire) begin
        cnt_d = cnt_q == 3'd3 ? 3'd0 : cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          addr_d  = addr_q + 26'd4;
          len_d   = len_q - 16'd1;
          state_d = len_q == 16'd1 ? DONE : RD_ISSUE;
        end
      end
      default: if (tx_fire) state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    rx_ready_d = state_d == IDLE || state_d == HDR || state_d == WR_COLLECT;
    tx_valid_d = state_d == RD_SEND || state_d == STATUS;
    usb_rd_d   = state_d == RD_ISSUE;
    usb_wr_d   = state_d == WR_ISSUE;
    tx_data_d  = !tx_valid_d ? 8'h00 : state_d == STATUS ? status_d :
                 cnt_d[1] ? (cnt_d[0] ? data_d[31:24] : data_d[23:16]) :
                            (cnt_d[0] ? data_d[15:8]  : data_d[7:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      data_q     <= '0;
      status_q   <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      usb_rd_q   <= 1'b0;
      usb_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      data_q     <= data_d;
      status_q   <= status_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      usb_rd_q   <= usb_rd_d;
      usb_wr_q   <= usb_wr_d;
    end
  end
  assign rx_ready        = rx_ready_q;
  assign tx_valid        = tx_valid_q;
  assign tx_data         = tx_data_q;
  assign usb.usb_rd      = usb_rd_q;
  assign usb.usb_wr      = usb_wr_q;
  assign usb.usb_addr    = addr_q;
  assign usb.usb_wr_data = data_q;
endmodule

// File: tb/tb_usb_cmd_engine.sv
// tb_usb_cmd_engine: directed packet vectors with a bench-side mux responder and byte logs.
module tb_usb_cmd_engine;
`ifdef USB_CMD_STATUS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  mux_usb_interface bus ();
  usb_cmd_engine dut (.clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
                      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .usb(bus.usb));

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [15:0] len;
    logic [63:0] pay;
    logic [63:0] rdat;
    int          stall;
    int          dly;
    bit          tog;
    bit          junk;
    int          nacc;
    logic [25:0] a0, a1;
    logic [31:0] d0, d1;
    int          ntx;
    logic [63:0] tx;
  } vec_t;
  vec_t vt[6];

  int n_vec = 0, n_bad = 0, viol = 0;
  logic [7:0]  rx_q[$], tx_b[$];
  logic [25:0] wr_a[$], rd_a[$];
  logic [31:0] wr_d[$], rd_q[$];
  int stall = 0, dly = 0, wr_wait = 0, dly_c = 0;
  bit tog = 0, junk = 0, rd_hold = 0, pend = 0, rd_prev = 0, tx_next = 0;
  logic [25:0] wa0;
  logic [31:0] wd0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear();
    rx_q.delete(); tx_b.delete(); wr_a.delete(); rd_a.delete(); wr_d.delete(); rd_q.delete();
    viol = 0; pend = 0; wr_wait = 0; tx_next = 0; rd_prev = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (tx_next && !tx_valid) viol++;
    tx_next = 0;
    if (bus.usb_rd && bus.usb_wr) viol++;
    if (bus.usb_rd && rd_prev) viol++;
    rd_prev = bus.usb_rd;
    if (rx_ready && (tx_valid || bus.usb_rd || bus.usb_wr)) viol++;
    if (bus.usb_wr) begin
      if (wr_wait == 0) begin
        wa0 = bus.usb_addr; wd0 = bus.usb_wr_data;
      end else if (bus.usb_addr !== wa0 || bus.usb_wr_data !== wd0) viol++;
      bus.usb_wr_ready = wr_wait >= stall;
      if (bus.usb_wr_ready) begin
        wr_a.push_back(bus.usb_addr); wr_d.push_back(bus.usb_wr_data); wr_wait = 0;
      end else wr_wait++;
    end else bus.usb_wr_ready = 1'b0;
    if (pend && !rd_hold) begin
      if (dly_c == 0) begin
        bus.usb_rd_valid = 1'b1;
        bus.usb_rd_data = rd_q.size() > 0 ? rd_q.pop_front() : 32'h0;
        pend = 0; tx_next = 1;
      end else begin
        bus.usb_rd_valid = 1'b0; dly_c--;
      end
    end else begin
      bus.usb_rd_valid = junk && !pend;
      bus.usb_rd_data = 32'hBAD0BAD0;
    end
    if (bus.usb_rd) begin
      rd_a.push_back(bus.usb_addr); pend = 1; dly_c = dly;
    end
    tx_ready = tog ? ~tx_ready : 1'b1;
    if (tx_valid && tx_ready) tx_b.push_back(tx_data);
    rx_valid = rx_q.size() > 0;
    rx_data = rx_valid ? rx_q[0] : 8'h00;
    if (rx_valid && rx_ready) void'(rx_q.pop_front());
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic push_hdr(input logic [7:0] op, input logic [31:0] a, input logic [15:0] l);
    rx_q.push_back(op);
    for (int k = 0; k < 4; k++) rx_q.push_back(a[8*k +: 8]);
    rx_q.push_back(l[7:0]); rx_q.push_back(l[15:8]);
  endtask

  function automatic logic [71:0] txpack();
    logic [71:0] r = '0;
    for (int k = 0; k < tx_b.size() && k < 9; k++) r[8*k +: 8] = tx_b[k];
    return r;
  endfunction

  function automatic logic [71:0] outs();
    return 72'({rx_ready, tx_valid, tx_data, bus.usb_rd, bus.usb_wr, bus.usb_addr, bus.usb_wr_data});
  endfunction

  initial begin
    logic [71:0] exp_tx;
    int n_acc;
    bit is_wr;
    vt[0] = '{op:8'h02, addr:32'h00001000, len:16'd2, pay:64'h8877665544332211, rdat:64'h0, stall:3, dly:0,
              tog:0, junk:0, nacc:2, a0:26'h0001000, a1:26'h0001004, d0:32'h44332211, d1:32'h88776655, ntx:0, tx:64'h0};
    vt[1] = '{op:8'h01, addr:32'h03FFFFFC, len:16'd2, pay:64'h0, rdat:64'h01020304_DEADBEEF, stall:0, dly:0,
              tog:0, junk:1, nacc:2, a0:26'h3FFFFFC, a1:26'h0000000, d0:32'h0, d1:32'h0, ntx:8, tx:64'h01020304_DEADBEEF};
    vt[2] = '{op:8'h01, addr:32'h03FFFFFC, len:16'd2, pay:64'h0, rdat:64'h01020304_DEADBEEF, stall:0, dly:1,
              tog:1, junk:0, nacc:2, a0:26'h3FFFFFC, a1:26'h0000000, d0:32'h0, d1:32'h0, ntx:8, tx:64'h01020304_DEADBEEF};
    vt[3] = '{op:8'h02, addr:32'hFC000010, len:16'd1, pay:64'hCAFEF00D, rdat:64'h0, stall:0, dly:0,
              tog:0, junk:1, nacc:1, a0:26'h0000010, a1:26'h0, d0:32'hCAFEF00D, d1:32'h0, ntx:0, tx:64'h0};
    vt[4] = '{op:8'h01, addr:32'h00000100, len:16'd0, pay:64'h0, rdat:64'h0, stall:0, dly:0,
              tog:0, junk:1, nacc:0, a0:26'h0, a1:26'h0, d0:32'h0, d1:32'h0, ntx:0, tx:64'h0};
    vt[5] = '{op:8'h01, addr:32'h00002000, len:16'd1, pay:64'h0, rdat:64'hA1B2C3D4, stall:0, dly:3,
              tog:0, junk:1, nacc:1, a0:26'h0002000, a1:26'h0, d0:32'h0, d1:32'h0, ntx:4, tx:64'hA1B2C3D4};
    bus.usb_wr_ready = 1'b0; bus.usb_rd_valid = 1'b0; bus.usb_rd_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 72'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_reset", 72'(rx_ready), 72'h1);

    for (int i = 0; i < 6; i++) begin
      clear();
      stall = vt[i].stall; dly = vt[i].dly; tog = vt[i].tog; junk = vt[i].junk;
      push_hdr(vt[i].op, vt[i].addr, vt[i].len);
      if (vt[i].op == 8'h02)
        for (int k = 0; k < 4 * int'(vt[i].len); k++) rx_q.push_back(vt[i].pay[8*k +: 8]);
      rd_q.push_back(vt[i].rdat[31:0]); rd_q.push_back(vt[i].rdat[63:32]);
      run(100);
      is_wr = vt[i].op == 8'h02;
      n_acc = is_wr ? wr_a.size() : rd_a.size();
      chk($sformatf("v%0d accesses", i), 72'(n_acc), 72'(vt[i].nacc));
      chk($sformatf("v%0d stray_accesses", i), 72'(is_wr ? rd_a.size() : wr_a.size()), 72'h0);
      if (n_acc > 0 && vt[i].nacc > 0) chk($sformatf("v%0d addr0", i), 72'(is_wr ? wr_a[0] : rd_a[0]), 72'(vt[i].a0));
      if (n_acc > 1 && vt[i].nacc > 1) chk($sformatf("v%0d addr1", i), 72'(is_wr ? wr_a[1] : rd_a[1]), 72'(vt[i].a1));
      if (is_wr && wr_d.size() > 0) chk($sformatf("v%0d wdata0", i), 72'(wr_d[0]), 72'(vt[i].d0));
      if (is_wr && wr_d.size() > 1) chk($sformatf("v%0d wdata1", i), 72'(wr_d[1]), 72'(vt[i].d1));
      exp_tx = 72'(vt[i].tx);
      if (ST == 1) exp_tx[8*vt[i].ntx +: 8] = 8'hA5;
      chk($sformatf("v%0d tx_count", i), 72'(tx_b.size()), 72'(vt[i].ntx + ST));
      chk($sformatf("v%0d tx_bytes", i), txpack(), exp_tx);
      chk($sformatf("v%0d rx_drained", i), 72'(rx_q.size()), 72'h0);
      chk($sformatf("v%0d protocol", i), 72'(viol), 72'h0);
    end

    // unknown opcode, then a one-word write
    clear(); stall = 1; dly = 0; tog = 0; junk = 0;
    rx_q.push_back(8'h7F);
    push_hdr(8'h02, 32'h00000020, 16'd1);
    for (int k = 1; k <= 4; k++) rx_q.push_back(8'(k));
    run(60);
    chk("unk writes", 72'(wr_a.size()), 72'h1);
    if (wr_a.size() > 0) chk("unk addr", 72'(wr_a[0]), 72'h20);
    if (wr_d.size() > 0) chk("unk wdata", 72'(wr_d[0]), 72'h04030201);
    chk("unk tx_count", 72'(tx_b.size()), 72'(2 * ST));
    chk("unk tx_bytes", txpack(), ST == 1 ? 72'hA5EE : 72'h0);
    chk("unk rx_drained", 72'(rx_q.size()), 72'h0);
    chk("unk protocol", 72'(viol), 72'h0);

    // reset while waiting for read data
    clear(); rd_hold = 1; junk = 0;
    push_hdr(8'h01, 32'h00000040, 16'd1);
    run(14);
    chk("rst reached_rd_wait", 72'(rd_a.size()), 72'h1);
    chk("rst rx_ready_busy", 72'(rx_ready), 72'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst outputs", outs(), 72'h0);
    rst = 1'b0; rd_hold = 0;
    clear();
    push_hdr(8'h01, 32'h00000044, 16'd1);
    rd_q.push_back(32'h55AA1234);
    run(40);
    chk("post_rst rd_count", 72'(rd_a.size()), 72'h1);
    if (rd_a.size() > 0) chk("post_rst addr", 72'(rd_a[0]), 72'h44);
    chk("post_rst tx_count", 72'(tx_b.size()), 72'(4 + ST));
    chk("post_rst tx_bytes", txpack(), ST == 1 ? 72'hA5_55AA1234 : 72'h55AA1234);
    chk("post_rst protocol", 72'(viol), 72'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
